// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : core_sequencer
// Brief   : Layer controller: per kernel position loads weights, streams
//           activations, executes, drains OFIFO and swaps psum banks; then dumps.
// Rev     : 1.0  initial release
// ============================================================================
module core_sequencer #(
  parameter int          ROW      = 8,
  parameter int          LEN_NIJ  = 16,
  parameter int          NUM_KIJ  = 9,
  parameter logic [10:0] W_BASE   = 11'd0,
  parameter logic [10:0] ACT_BASE = 11'd512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        o_ready_l0,
  input  logic        ofifo_valid,
  output logic        cen_act_wgt,
  output logic        wen_act_wgt,
  output logic [10:0] addr_act_wgt,
  output logic [6:0]  inst,
  output logic        ptr_clr,
  output logic        first_pass,
  output logic [3:0]  kij_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD_W = 4'd1,
    S_KLOAD  = 4'd2,
    S_ACT    = 4'd3,
    S_EXEC   = 4'd4,
    S_DRAIN  = 4'd5,
    S_SWAP   = 4'd6,
    S_DUMP   = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  localparam logic [10:0] c_row_n    = 11'(ROW);
  localparam logic [10:0] c_row_last = 11'(ROW - 1);
  localparam logic [10:0] c_len_n    = 11'(LEN_NIJ);
  localparam logic [10:0] c_len_last = 11'(LEN_NIJ - 1);
  localparam logic [3:0]  c_kij_last = 4'(NUM_KIJ - 1);

  state_t      r_state, w_state_nxt;
  logic [10:0] r_cnt, w_cnt_nxt;
  logic [10:0] r_wptr, w_wptr_nxt;
  logic [10:0] w_rd_addr;
  logic [3:0]  r_kij, w_kij_nxt;
  logic        r_rchip, w_rchip_nxt;
  logic        w_rd_en;
  logic        r_wr_pend;
  logic        w_active;
  logic [6:0]  w_inst;

  // Weight slots for consecutive kernel positions are contiguous, so a
  // running pointer replaces the kij*row product.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wptr_nxt  = r_wptr;
    w_kij_nxt   = r_kij;
    w_rchip_nxt = r_rchip;
    w_rd_en     = 1'b0;
    w_rd_addr   = r_wptr;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD_W;
          w_cnt_nxt   = '0;
          w_kij_nxt   = '0;
          w_rchip_nxt = 1'b0;
          w_wptr_nxt  = W_BASE;
        end
      end
      S_LOAD_W: begin
        if (r_cnt == c_row_n) begin
          w_state_nxt = S_KLOAD;
          w_cnt_nxt   = '0;
        end else if (o_ready_l0) begin
          w_rd_en    = 1'b1;
          w_rd_addr  = r_wptr;
          w_cnt_nxt  = r_cnt + 11'd1;
          w_wptr_nxt = r_wptr + 11'd1;
        end
      end
      S_KLOAD: begin
        w_cnt_nxt = r_cnt + 11'd1;
        if (r_cnt == c_row_last) begin
          w_state_nxt = S_ACT;
          w_cnt_nxt   = '0;
        end
      end
      S_ACT: begin
        if (r_cnt == c_len_n) begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = '0;
        end else if (o_ready_l0) begin
          w_rd_en   = 1'b1;
          w_rd_addr = ACT_BASE + r_cnt;
          w_cnt_nxt = r_cnt + 11'd1;
        end
      end
      S_EXEC: begin
        w_cnt_nxt = r_cnt + 11'd1;
        if (r_cnt == c_len_last) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end
      end
      S_DRAIN: begin
        if (ofifo_valid) begin
          w_cnt_nxt = r_cnt + 11'd1;
          if (r_cnt == c_len_last) begin
            w_state_nxt = S_SWAP;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_SWAP: begin
        if (r_kij == c_kij_last) begin
          w_state_nxt = S_DUMP;
        end else begin
          w_state_nxt = S_LOAD_W;
          w_kij_nxt   = r_kij + 4'd1;
          w_rchip_nxt = ~r_rchip;
        end
      end
      S_DUMP: begin
        w_cnt_nxt = r_cnt + 11'd1;
        if (r_cnt == c_len_last) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_active  = (r_state != S_IDLE);
    w_inst    = '0;
    w_inst[0] = (r_state == S_KLOAD);
    w_inst[1] = (r_state == S_EXEC);
    w_inst[2] = r_wr_pend;
    w_inst[3] = (r_state == S_DRAIN) && ofifo_valid;
    w_inst[4] = (r_state == S_DUMP);
    w_inst[5] = r_rchip && w_active;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_wptr       <= '0;
      r_kij        <= '0;
      r_rchip      <= 1'b0;
      r_wr_pend    <= 1'b0;
      cen_act_wgt  <= 1'b1;
      addr_act_wgt <= '0;
      inst         <= '0;
      ptr_clr      <= 1'b0;
      first_pass   <= 1'b0;
      kij_idx      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_wptr       <= w_wptr_nxt;
      r_kij        <= w_kij_nxt;
      r_rchip      <= w_rchip_nxt;
      // SRAM returns data one cycle after the read, so the L0 write trails it
      r_wr_pend    <= w_rd_en;
      cen_act_wgt  <= ~w_rd_en;
      addr_act_wgt <= w_rd_en ? w_rd_addr : (w_active ? addr_act_wgt : 11'd0);
      inst         <= w_inst;
      ptr_clr      <= (r_state == S_SWAP) || (r_state == S_DONE);
      first_pass   <= w_active && (r_kij == 4'd0);
      kij_idx      <= w_active ? r_kij : 4'd0;
      busy         <= w_active;
      done         <= (r_state == S_DONE);
    end
  end

  assign wen_act_wgt = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_core_sequencer
// Brief   : Scoreboard bench for core_sequencer: SRAM address order, per-pass
//           instruction counts, rchip/kij tracking, latency, stalls and reset.
// Rev     : 1.0  initial release
// ============================================================================
module tb_core_sequencer;

  localparam int          ROW  = 8;
  localparam int          LEN  = 16;
  localparam int          NKIJ = 9;
  localparam logic [10:0] WB   = 11'd0;
  localparam logic [10:0] AB   = 11'd512;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        o_ready_l0 = 1'b1;
  logic        ofifo_valid = 1'b1;
  logic        cen_act_wgt, wen_act_wgt;
  logic [10:0] addr_act_wgt;
  logic [6:0]  inst;
  logic        ptr_clr, first_pass, busy, done;
  logic [3:0]  kij_idx;

  core_sequencer #(
    .ROW(ROW), .LEN_NIJ(LEN), .NUM_KIJ(NKIJ), .W_BASE(WB), .ACT_BASE(AB)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .o_ready_l0(o_ready_l0),
    .ofifo_valid(ofifo_valid), .cen_act_wgt(cen_act_wgt), .wen_act_wgt(wen_act_wgt),
    .addr_act_wgt(addr_act_wgt), .inst(inst), .ptr_clr(ptr_clr),
    .first_pass(first_pass), .kij_idx(kij_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  task automatic check_idle_vec(input string tag);
    check_eq(tag, {4'd0, cen_act_wgt, wen_act_wgt, addr_act_wgt, inst, ptr_clr,
                   first_pass, kij_idx, busy, done}, 32'h0C00_0000);
  endtask

  logic [10:0] addr_q[$];
  bit  mon_en = 1'b0;
  bit  seen_kload;
  bit  rdy_toggle = 1'b0;
  int  m_kij, n_wr_w, n_wr_a, n_kload, n_exec, n_rd, n_dump, n_swap, n_ptr;
  int  t_exec, t_done_prev, t_done_last, done_cnt, stall_kij, t0;
  logic [10:0] e_addr;

  task automatic clear_pass();
    n_wr_w = 0; n_wr_a = 0; n_kload = 0; n_exec = 0; n_rd = 0; seen_kload = 1'b0;
  endtask

  task automatic clear_layer();
    clear_pass();
    m_kij = 0; n_dump = 0; n_swap = 0; n_ptr = 0;
  endtask

  task automatic push_layer();
    for (int k = 0; k < NKIJ; k++) begin
      for (int i = 0; i < ROW; i++) addr_q.push_back(11'(WB + k * ROW + i));
      for (int i = 0; i < LEN; i++) addr_q.push_back(11'(AB + i));
    end
  endtask

  // Monitor: pops expected addresses on each read, tallies per-pass activity.
  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (!cen_act_wgt) begin
        if (addr_q.size() == 0) begin
          check_eq("addr_q_nonempty", addr_q.size(), 1);
        end else begin
          e_addr = addr_q.pop_front();
          check_eq("addr", addr_act_wgt, e_addr);
        end
      end
      if (inst[2]) begin
        if (seen_kload) n_wr_a++;
        else n_wr_w++;
      end
      if (inst[0]) begin
        seen_kload = 1'b1;
        n_kload++;
      end
      if (inst[1]) begin
        if (n_exec == 0) t_exec = cyc;
        n_exec++;
      end
      if (inst[3]) n_rd++;
      if (inst[4]) begin
        n_dump++;
        check_eq("dump_rchip", inst[5], (NKIJ - 1) % 2);
      end
      if (ptr_clr) n_ptr++;
      if (ptr_clr && !done) begin
        check_eq("wr_weights", n_wr_w, ROW);
        check_eq("wr_acts", n_wr_a, LEN);
        check_eq("kload_cycles", n_kload, ROW);
        check_eq("exec_cycles", n_exec, LEN);
        check_eq("ofifo_reads", n_rd, LEN);
        check_eq("kij_idx", kij_idx, m_kij);
        check_eq("rchip", inst[5], m_kij % 2);
        check_eq("first_pass", first_pass, (m_kij == 0) ? 1 : 0);
        check_eq("inst6", inst[6], 0);
        check_eq("drain_gap", cyc - t_exec, (m_kij == stall_kij) ? 2 * LEN + 5 : 2 * LEN);
        m_kij++;
        n_swap++;
        clear_pass();
      end
      if (done) begin
        check_eq("swap_count", n_swap, NKIJ);
        check_eq("ptr_clr_count", n_ptr, NKIJ + 1);
        check_eq("dump_cycles", n_dump, LEN);
        done_cnt++;
        t_done_prev = t_done_last;
        t_done_last = cyc;
        clear_layer();
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      o_ready_l0 = rdy_toggle ? ~o_ready_l0 : 1'b1;
    end
  end

  task automatic start_layer();
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b1;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) begin
      @(negedge clk);
      #1;
    end
    if (done_cnt < target) check_eq("done_timeout", done_cnt, target);
  endtask

  initial begin
    stall_kij = -1;
    done_cnt  = 0;
    clear_layer();

    repeat (3) @(posedge clk);
    #1;
    check_idle_vec("reset_outputs");
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_idle_vec("idle_outputs");

    // Stall-free layer: address order, counts and end-to-end latency
    push_layer(); clear_layer(); mon_en = 1'b1;
    start_layer();
    @(posedge clk); #1; start = 1'b0;
    wait_done(1, 3000);
    check_eq("latency", t_done_last - (t0 + 1), 620);
    check_eq("addr_left", addr_q.size(), 0);

    // L0 back-pressure throughout plus an OFIFO gap in the kij=3 drain
    done_cnt = 0; push_layer(); clear_layer();
    rdy_toggle = 1'b1; stall_kij = 3;
    start_layer();
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 5000 && !(m_kij == 3 && n_rd >= 4); i++) begin
      @(negedge clk); #1;
    end
    if (m_kij == 3 && n_rd >= 4) begin
      ofifo_valid = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      ofifo_valid = 1'b1;
    end else begin
      check_eq("stall_point_kij", m_kij, 3);
    end
    wait_done(1, 6000);
    check_eq("addr_left_stall", addr_q.size(), 0);
    rdy_toggle = 1'b0; stall_kij = -1;

    // Asynchronous reset during EXEC of kij=4
    done_cnt = 0; push_layer(); clear_layer();
    start_layer();
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 3000 && !(m_kij == 4 && inst[1]); i++) begin
      @(negedge clk); #1;
    end
    check_eq("reset_point_kij", m_kij, 4);
    reset  = 1'b0;
    mon_en = 1'b0;
    #1;
    check_idle_vec("reset_mid_exec");
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_no_done", done, 0);
    reset = 1'b1;
    addr_q.delete();
    clear_layer();

    // Fresh layer after reset must start from kij 0
    done_cnt = 0; push_layer(); mon_en = 1'b1;
    start_layer();
    @(posedge clk); #1; start = 1'b0;
    wait_done(1, 3000);
    check_eq("latency_after_reset", t_done_last - (t0 + 1), 620);
    check_eq("addr_left_reset", addr_q.size(), 0);

    // start held high: back-to-back layers
    done_cnt = 0; push_layer(); push_layer(); clear_layer();
    start_layer();
    wait_done(2, 5000);
    start = 1'b0;
    check_eq("restart_period", t_done_last - t_done_prev, 621);
    repeat (20) @(negedge clk);
    #1;
    check_eq("done_pulses", done_cnt, 2);
    check_eq("addr_left_held", addr_q.size(), 0);
    check_eq("idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
